// File: rtl/dlf_pkg.sv
// Shared types and arithmetic helpers for the second-generation loop filter.
package dlf_pkg;

   // Filter mode encodings; 2'b11 behaves as MODE_PIIIR.
   typedef enum logic [1:0] {
      MODE_P     = 2'b00,
      MODE_PI    = 2'b01,
      MODE_PIIIR = 2'b10
   } dlf_mode_e;

   // Working width for all saturating arithmetic; every datapath width fits inside.
   localparam int unsigned SAT_MAX_W = 64;

   typedef logic signed [SAT_MAX_W-1:0] wide_t;

   // Largest positive value of a w-bit two's complement number.
   function automatic wide_t sat_hi(input int unsigned w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   // Clip x into the signed w-bit range.
   function automatic wide_t sat_val(input wide_t x, input int unsigned w);
      wide_t hi;
      wide_t lo;
      hi = sat_hi(w);
      lo = -hi - wide_t'(1);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // High when sat_val would clip x.
   function automatic logic sat_clip(input wide_t x, input int unsigned w);
      wide_t hi;
      wide_t lo;
      hi = sat_hi(w);
      lo = -hi - wide_t'(1);
      return (x > hi) || (x < lo);
   endfunction

   // Magnitude of a signed value.
   function automatic wide_t abs_val(input wide_t x);
      return (x < 0) ? -x : x;
   endfunction

endpackage

// File: rtl/dlf_lock_det.sv
// Lock detector: counts consecutive in-limit phase errors.
module dlf_lock_det
   import dlf_pkg::*;
#(
   parameter int unsigned IN_W   = 21,
   parameter int unsigned LOCK_W = 10
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en_i,
   input  logic                   sample_i,
   input  logic signed [IN_W-1:0] err_i,
   input  logic [IN_W-2:0]        thresh_i,
   input  logic [LOCK_W-1:0]      lock_cnt_i,
   output logic                   locked_o
);

   logic [LOCK_W-1:0] cnt_q, cnt_d;
   logic              locked_q, locked_d;
   logic              in_lim_c;

   // Next counter value on each output sample, saturating at all-ones.
   always_comb begin
      cnt_d    = cnt_q;
      in_lim_c = abs_val(wide_t'(err_i)) <= wide_t'(thresh_i);
      if (sample_i) begin
         if (!in_lim_c)
            cnt_d = '0;
         else if (cnt_q != '1)
            cnt_d = cnt_q + LOCK_W'(1);
      end
      locked_d = (cnt_d >= lock_cnt_i);
      if (!en_i) begin
         cnt_d    = '0;
         locked_d = 1'b0;
      end
   end

   // Counter and lock state registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign locked_o = locked_q;

endmodule

// File: rtl/dlf_pi_gen2.sv
// ADPLL digital loop filter: phase error, PI with optional IIR smoother, saturation.
module dlf_pi_gen2
   import dlf_pkg::*;
#(
   parameter int unsigned IN_W   = 21,
   parameter int unsigned NC_W   = 15,
   parameter int unsigned TRUNC  = 3,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned FRAC   = 12,
   parameter int unsigned ACC_W  = 40,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned LOCK_W = 10
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic                     hold,
   input  logic                     in_valid,
   input  logic [IN_W-1:0]          dec_in,
   input  logic [NC_W-1:0]          nc_in,
   input  logic signed [COEF_W-1:0] kp,
   input  logic signed [COEF_W-1:0] ki,
   input  logic [3:0]               iir_shift,
   input  logic [IN_W-2:0]          lock_thresh,
   input  logic [LOCK_W-1:0]        lock_cnt,
   input  logic                     sat_clr,
   output logic signed [IN_W-1:0]   err_out,
   output logic signed [OUT_W-1:0]  dlf_out,
   output logic                     out_valid,
   output logic                     locked,
   output logic                     sat_flag
);

   localparam int unsigned PROD_W   = COEF_W + IN_W;
   localparam int unsigned NC_SHIFT = IN_W - NC_W;
   localparam logic [IN_W-1:0] TRUNC_MASK = ~((IN_W'(1) << TRUNC) - IN_W'(1));

   // Stage 1: phase error
   logic signed [IN_W-1:0]  err_q, err_d;
   logic                    v1_q, v1_d;
   // Stage 2: proportional term and integrator
   logic signed [ACC_W-1:0] p_q, p_d;
   logic signed [ACC_W-1:0] integ_q, integ_d;
   logic signed [IN_W-1:0]  err2_q, err2_d;
   logic                    v2_q, v2_d;
   // Stage 3: PI sum
   logic signed [ACC_W-1:0] s_q, s_d;
   logic signed [IN_W-1:0]  err3_q, err3_d;
   logic                    v3_q, v3_d;
   // Stage 4: IIR state and output
   logic signed [ACC_W-1:0] y_q, y_d;
   logic signed [OUT_W-1:0] dlf_q, dlf_d;
   logic                    ov_q, ov_d;
   logic                    sat_q, sat_d;

   logic signed [IN_W-1:0]   err_c;
   logic signed [PROD_W-1:0] kp_prod_c, ki_prod_c;
   wide_t                    integ_sum_c, s_sum_c, y_step_c, out_wide_c;
   logic                     iir_on_c;
   logic                     clip_c;

   // Pipeline next-state; each stage loads only when its valid bit is set.
   always_comb begin
      err_c       = IN_W'((dec_in & TRUNC_MASK) - (IN_W'(nc_in) << NC_SHIFT));
      kp_prod_c   = PROD_W'(kp) * PROD_W'(err_q);
      ki_prod_c   = PROD_W'(ki) * PROD_W'(err_q);
      integ_sum_c = wide_t'(integ_q) + wide_t'(ki_prod_c);
      s_sum_c     = wide_t'(p_q) + wide_t'(integ_q);
      y_step_c    = wide_t'(y_q) + ((wide_t'(s_q) - wide_t'(y_q)) >>> iir_shift);
      iir_on_c    = mode[1] && (iir_shift != 4'd0);

      err_d   = err_q;
      v1_d    = in_valid;
      p_d     = p_q;
      integ_d = integ_q;
      err2_d  = err2_q;
      v2_d    = v1_q;
      s_d     = s_q;
      err3_d  = err3_q;
      v3_d    = v2_q;
      y_d     = y_q;
      dlf_d   = dlf_q;
      ov_d    = v3_q;
      clip_c  = 1'b0;

      if (in_valid)
         err_d = err_c;

      if (v1_q) begin
         p_d    = ACC_W'(kp_prod_c);
         err2_d = err_q;
         if (mode == MODE_P) begin
            integ_d = '0;
         end else if (!hold) begin
            integ_d = ACC_W'(sat_val(integ_sum_c, ACC_W));
            clip_c  = clip_c | sat_clip(integ_sum_c, ACC_W);
         end
      end

      if (v2_q) begin
         s_d    = ACC_W'(sat_val(s_sum_c, ACC_W));
         clip_c = clip_c | sat_clip(s_sum_c, ACC_W);
         err3_d = err2_q;
      end

      if (v3_q) begin
         if (iir_on_c) begin
            y_d    = ACC_W'(sat_val(y_step_c, ACC_W));
            clip_c = clip_c | sat_clip(y_step_c, ACC_W);
         end else begin
            y_d = s_q;
         end
      end

      out_wide_c = wide_t'(y_d) >>> FRAC;
      if (v3_q) begin
         dlf_d  = OUT_W'(sat_val(out_wide_c, OUT_W));
         clip_c = clip_c | sat_clip(out_wide_c, OUT_W);
      end

      // A clip in the same cycle as sat_clr keeps the flag set.
      sat_d = clip_c ? 1'b1 : (sat_clr ? 1'b0 : sat_q);

      if (!en) begin
         err_d   = '0;
         v1_d    = 1'b0;
         p_d     = '0;
         integ_d = '0;
         err2_d  = '0;
         v2_d    = 1'b0;
         s_d     = '0;
         err3_d  = '0;
         v3_d    = 1'b0;
         y_d     = '0;
         dlf_d   = '0;
         ov_d    = 1'b0;
         sat_d   = sat_q;
      end
   end

   // Pipeline and flag registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_q   <= '0;
         v1_q    <= 1'b0;
         p_q     <= '0;
         integ_q <= '0;
         err2_q  <= '0;
         v2_q    <= 1'b0;
         s_q     <= '0;
         err3_q  <= '0;
         v3_q    <= 1'b0;
         y_q     <= '0;
         dlf_q   <= '0;
         ov_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         err_q   <= err_d;
         v1_q    <= v1_d;
         p_q     <= p_d;
         integ_q <= integ_d;
         err2_q  <= err2_d;
         v2_q    <= v2_d;
         s_q     <= s_d;
         err3_q  <= err3_d;
         v3_q    <= v3_d;
         y_q     <= y_d;
         dlf_q   <= dlf_d;
         ov_q    <= ov_d;
         sat_q   <= sat_d;
      end
   end

   dlf_lock_det #(
      .IN_W   (IN_W),
      .LOCK_W (LOCK_W)
   ) u_lock_det (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (en),
      .sample_i   (v3_q),
      .err_i      (err3_q),
      .thresh_i   (lock_thresh),
      .lock_cnt_i (lock_cnt),
      .locked_o   (locked)
   );

   assign err_out   = err_q;
   assign dlf_out   = dlf_q;
   assign out_valid = ov_q;
   assign sat_flag  = sat_q;

endmodule
